// File: rtl/cache_types_pkg.sv
// ---------------------------------------------------------------------------
// cache_types_pkg
// Shared types for the cache miss path: default associativity, the way-index
// type and the miss-controller state encoding.
// ---------------------------------------------------------------------------
package cache_types_pkg;

    // Default associativity of the cache and the matching way-index width.
    localparam int DEFAULT_WAYS  = 8;
    localparam int DEFAULT_WAY_W = $clog2(DEFAULT_WAYS);

    typedef logic [DEFAULT_WAY_W-1:0] way_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LRU_REQ   = 3'd1,
        S_LRU_WAIT  = 3'd2,
        S_WRITEBACK = 3'd3,
        S_FILL      = 3'd4,
        S_DONE      = 3'd5
    } miss_state_e;

endpackage

// File: rtl/first_zero_enc.sv
// ---------------------------------------------------------------------------
// first_zero_enc
// Priority encoder returning the index of the lowest-numbered 0 bit.
//   bits     in   N      vector to search (way valid bits)
//   idx      out  IDX_W  lowest index whose bit is 0 (0 when none)
//   any_zero out  1      at least one bit is 0
// ---------------------------------------------------------------------------
module first_zero_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     bits,
    output logic [IDX_W-1:0] idx,
    output logic             any_zero
);

    // Scan from the top down so the lowest zero index is the last one written.
    always_comb begin
        idx      = '0;
        any_zero = ~(&bits);
        for (int i = N - 1; i >= 0; i--) begin
            idx = bits[i] ? idx : IDX_W'(i);
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// cache_miss_ctrl
// Miss-handling controller for the set-associative cache. Picks a victim way
// (first invalid way, else the pseudo-LRU way), writes the victim back when
// dirty, fills the line from memory and pulses done to the datapath.
//   clk, rst     clock, synchronous active-high reset
//   miss_req     lookup missed (sampled only in IDLE)
//   way_valid    valid bits of the indexed set
//   way_dirty    dirty bits of the indexed set
//   load_lru     one-cycle request to pseudo_lru
//   lru_valid    pseudo_lru result valid
//   lru_way      pseudo_lru victim way
//   victim_way   registered victim index (array way select)
//   pmem_write   writeback request, held until pmem_resp
//   pmem_read    fill request, held until pmem_resp
//   pmem_resp    memory completion pulse
//   fill_we      write data/tag of victim_way, set valid, clear dirty
//   done         one-cycle completion pulse
// ---------------------------------------------------------------------------
module cache_miss_ctrl
    import cache_types_pkg::*;
#(
    parameter int WAYS  = DEFAULT_WAYS,
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             miss_req,
    input  logic [WAYS-1:0]  way_valid,
    input  logic [WAYS-1:0]  way_dirty,
    output logic             load_lru,
    input  logic             lru_valid,
    input  logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] victim_way,
    output logic             pmem_write,
    output logic             pmem_read,
    input  logic             pmem_resp,
    output logic             fill_we,
    output logic             done
);

    miss_state_e      state_r;
    miss_state_e      state_nx_s;
    logic [WAY_W-1:0] victim_nx_s;
    logic [WAY_W-1:0] inv_idx_s;
    logic             inv_any_s;

    first_zero_enc #(
        .N     (WAYS),
        .IDX_W (WAY_W)
    ) u_first_zero (
        .bits     (way_valid),
        .idx      (inv_idx_s),
        .any_zero (inv_any_s)
    );

    // State and victim register; reset abandons any outstanding memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            victim_way <= '0;
        end else begin
            state_r    <= state_nx_s;
            victim_way <= victim_nx_s;
        end
    end

    // Next-state and victim selection.
    always_comb begin
        state_nx_s  = state_r;
        victim_nx_s = victim_way;
        case (state_r)
            S_IDLE: begin
                if (miss_req) begin
                    if (inv_any_s) begin
                        // An empty way needs neither LRU nor writeback.
                        victim_nx_s = inv_idx_s;
                        state_nx_s  = S_FILL;
                    end else begin
                        state_nx_s  = S_LRU_REQ;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_LRU_REQ: begin
                state_nx_s = S_LRU_WAIT;
            end
            S_LRU_WAIT: begin
                if (lru_valid) begin
                    victim_nx_s = lru_way;
                    state_nx_s  = way_dirty[lru_way] ? S_WRITEBACK : S_FILL;
                end else begin
                    state_nx_s = S_LRU_WAIT;
                end
            end
            S_WRITEBACK: begin
                if (pmem_resp) begin
                    state_nx_s = S_FILL;
                end else begin
                    state_nx_s = S_WRITEBACK;
                end
            end
            S_FILL: begin
                if (pmem_resp) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_FILL;
                end
            end
            S_DONE: begin
                state_nx_s = S_IDLE;
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // Moore outputs from the state register; fill_we also needs the response.
    always_comb begin
        load_lru   = (state_r == S_LRU_REQ);
        pmem_write = (state_r == S_WRITEBACK);
        pmem_read  = (state_r == S_FILL);
        fill_we    = (state_r == S_FILL) & pmem_resp;
        done       = (state_r == S_DONE);
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cache_miss_ctrl
// Scoreboard bench: the stimulus process issues misses and plays both the
// pseudo_lru and memory roles; a reference model pushes the expected outcome
// of each miss, and a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_cache_miss_ctrl;
    import cache_types_pkg::*;

    localparam int WAYS  = DEFAULT_WAYS;
    localparam int WAY_W = DEFAULT_WAY_W;

    logic            clk = 1'b0;
    logic            rst;
    logic            miss_req;
    logic [WAYS-1:0] way_valid;
    logic [WAYS-1:0] way_dirty;
    logic            load_lru;
    logic            lru_valid;
    way_t            lru_way;
    way_t            victim_way;
    logic            pmem_write;
    logic            pmem_read;
    logic            pmem_resp;
    logic            fill_we;
    logic            done;

    cache_miss_ctrl #(.WAYS(WAYS), .WAY_W(WAY_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .miss_req   (miss_req),
        .way_valid  (way_valid),
        .way_dirty  (way_dirty),
        .load_lru   (load_lru),
        .lru_valid  (lru_valid),
        .lru_way    (lru_way),
        .victim_way (victim_way),
        .pmem_write (pmem_write),
        .pmem_read  (pmem_read),
        .pmem_resp  (pmem_resp),
        .fill_we    (fill_we),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_loads = 0;
    int issued = 0;
    int tot_load = 0;
    int tot_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected outcome of one miss. lat counts cycles from the request cycle
    // to the done cycle inclusive.
    typedef struct {
        int victim;
        int uses_lru;
        int wb_n;
        int fill_n;
        int lat;
        int req;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: victim rule and cycle accounting from the state walk.
    function automatic exp_t model(input logic [WAYS-1:0] v, input logic [WAYS-1:0] d,
                                   input int lw, input int lru_dly, input int wb_dly,
                                   input int fill_dly);
        exp_t e;
        e.victim = -1;
        e.req    = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (!v[i] && e.victim < 0) e.victim = i;
        end
        e.fill_n = fill_dly;
        if (e.victim >= 0) begin
            e.uses_lru = 0;
            e.wb_n     = 0;
            e.lat      = 1 + fill_dly + 1;
        end else begin
            e.victim   = lw;
            e.uses_lru = 1;
            e.wb_n     = d[lw] ? wb_dly : 0;
            e.lat      = 1 + 1 + lru_dly + e.wb_n + fill_dly + 1;
        end
        return e;
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return load_lru;
            1:       return pmem_write;
            2:       return pmem_read;
            default: return 1'b0;
        endcase
    endfunction

    // Wait (bounded) at negedges until the selected DUT request is high.
    task automatic wait_sig(input int sel, input string name);
        int n = 0;
        while (sig(sel) == 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (sig(sel) == 1'b0) chk({name, "_timeout"}, 0, 1);
    endtask

    // Memory responder: request is visible now; respond in its n-th cycle.
    task automatic serve(input int n);
        repeat (n - 1) @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
    endtask

    // Issue one miss and service it; returns at the negedge of the DONE cycle.
    task automatic do_miss(input logic [WAYS-1:0] v, input logic [WAYS-1:0] d, input int lw,
                           input int lru_dly, input int wb_dly, input int fill_dly,
                           input bit hold, input bit spur);
        exp_t e;
        @(negedge clk);
        way_valid = v;
        way_dirty = d;
        miss_req  = 1'b1;
        e = model(v, d, lw, lru_dly, wb_dly, fill_dly);
        e.req = cyc;
        sb.push_back(e);
        issued++;
        exp_loads += e.uses_lru;
        @(negedge clk);
        if (!hold) miss_req = 1'b0;
        if (e.uses_lru != 0) begin
            if (spur) begin
                lru_valid = 1'b1;
                lru_way   = way_t'(lw ^ 1);
            end
            wait_sig(0, "load_lru");
            repeat (lru_dly) begin
                @(negedge clk);
                lru_valid = 1'b0;
                lru_way   = way_t'($urandom);
            end
            lru_valid = 1'b1;
            lru_way   = way_t'(lw);
            @(negedge clk);
            lru_valid = 1'b0;
            if (e.wb_n > 0) begin
                wait_sig(1, "pmem_write");
                serve(e.wb_n);
            end
        end
        wait_sig(2, "pmem_read");
        serve(fill_dly);
    endtask

    // Monitor: accumulate per-miss activity just before each rising edge.
    int   n_load, n_wr, n_rd, n_fill, n_ovl, fill_at;
    exp_t mon_e;

    always @(negedge clk) begin
        #3;
        if (rst) begin
            n_load = 0; n_wr = 0; n_rd = 0; n_fill = 0; n_ovl = 0; fill_at = 0;
        end else begin
            if (load_lru) begin
                n_load++;
                tot_load++;
            end
            if (pmem_write) n_wr++;
            if (pmem_read) n_rd++;
            if (pmem_write && pmem_read) n_ovl++;
            if (fill_we) begin
                n_fill++;
                fill_at = n_rd;
            end
            if (done) begin
                tot_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("victim_way", int'(victim_way), mon_e.victim);
                    chk("load_lru_cycles", n_load, mon_e.uses_lru);
                    chk("pmem_write_cycles", n_wr, mon_e.wb_n);
                    chk("pmem_read_cycles", n_rd, mon_e.fill_n);
                    chk("fill_we_count", n_fill, 1);
                    chk("fill_we_position", fill_at, mon_e.fill_n);
                    chk("rw_overlap", n_ovl, 0);
                    chk("latency", cyc - mon_e.req + 1, mon_e.lat);
                end
                n_load = 0; n_wr = 0; n_rd = 0; n_fill = 0; n_ovl = 0; fill_at = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WAYS-1:0] v;
        logic [WAYS-1:0] d;
        rst       = 1'b1;
        miss_req  = 1'b0;
        way_valid = '0;
        way_dirty = '0;
        lru_valid = 1'b0;
        lru_way   = '0;
        pmem_resp = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {load_lru, pmem_write, pmem_read, fill_we, done}, 0);
        chk("reset_victim", int'(victim_way), 0);
        rst = 1'b0;

        // Invalid way 3, immediate fill response.
        do_miss(8'b1111_0111, 8'h00, 0, 1, 1, 1, 1'b0, 1'b0);
        // Clean LRU victim 5, lru_valid 4 cycles after load_lru.
        do_miss(8'hFF, 8'h00, 5, 4, 1, 2, 1'b0, 1'b0);
        // Dirty LRU victim: 10 writeback cycles, 7 fill cycles, miss_req held.
        do_miss(8'hFF, 8'h20, 5, 1, 10, 7, 1'b1, 1'b0);
        miss_req = 1'b0;

        // Spurious pmem_resp while idle.
        @(negedge clk);
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("idle_after_spurious_resp", {load_lru, pmem_write, pmem_read, fill_we, done}, 0);
        // Spurious lru_valid during LRU_REQ, minimum clean-LRU latency.
        do_miss(8'hFF, 8'h00, 5, 1, 1, 1, 1'b0, 1'b1);

        // Reset on the third writeback cycle.
        @(negedge clk);
        way_valid = 8'hFF;
        way_dirty = 8'hFF;
        miss_req  = 1'b1;
        exp_loads++;
        @(negedge clk);
        miss_req = 1'b0;
        wait_sig(0, "rst_load_lru");
        @(negedge clk);
        lru_valid = 1'b1;
        lru_way   = way_t'(2);
        @(negedge clk);
        lru_valid = 1'b0;
        wait_sig(1, "rst_pmem_write");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midop_reset_outputs", {load_lru, pmem_write, pmem_read, fill_we, done}, 0);
        chk("midop_reset_victim", int'(victim_way), 0);
        rst = 1'b0;
        // A new miss after reset completes normally.
        do_miss(8'hFF, 8'h01, 0, 2, 3, 1, 1'b0, 1'b0);

        // Back-to-back random misses with miss_req held high.
        for (int it = 0; it < 1000; it++) begin
            v = ($urandom_range(0, 3) == 0) ? WAYS'($urandom) : '1;
            d = WAYS'($urandom);
            do_miss(v, d, $urandom_range(0, WAYS - 1), $urandom_range(1, 4),
                    $urandom_range(1, 4), $urandom_range(1, 4), 1'b1,
                    1'($urandom_range(0, 1)));
        end
        miss_req = 1'b0;

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("done_total", tot_done, issued);
        chk("load_lru_total", tot_load, exp_loads);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
